// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises per-thread dcache read/write requests onto one data-memory port.
// Request seen in IDLE -> mem valid next cycle; 4 cycles per grant with zero-wait memory; memory stalls hold the FSM.
module dmem_arbiter #(
  parameter int THREADS_PER_BLOCK  = 4,
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  localparam int TC_W = $clog2(THREADS_PER_BLOCK) + 1,
  localparam int GW   = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1,
  localparam int T    = THREADS_PER_BLOCK,
  localparam int AW   = DATA_MEM_ADDR_BITS,
  localparam int DW   = DATA_MEM_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TC_W-1:0]       thread_count,
  input  logic [T-1:0]          req_read_valid,
  input  logic [T-1:0][AW-1:0]  req_read_address,
  output logic [T-1:0]          req_read_ready,
  output logic [T-1:0][DW-1:0]  req_read_data,
  input  logic [T-1:0]          req_write_valid,
  input  logic [T-1:0][AW-1:0]  req_write_address,
  input  logic [T-1:0][DW-1:0]  req_write_data,
  output logic [T-1:0]          req_write_ready,
  output logic                  mem_read_valid,
  output logic [AW-1:0]         mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DW-1:0]         mem_read_data,
  output logic                  mem_write_valid,
  output logic [AW-1:0]         mem_write_address,
  output logic [DW-1:0]         mem_write_data,
  input  logic                  mem_write_ready,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_READ,
    S_MEM_WRITE,
    S_RESPOND,
    S_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        rr_ptr;
  logic [GW-1:0]        grant_q;
  logic                 rd_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;
  logic [T-1:0][DW-1:0] rdata_q;

  logic [T-1:0]         pend;
  logic [GW-1:0]        idx;
  logic                 pick_vld;
  logic [GW-1:0]        pick_id;
  logic                 pick_rd;

  // Threads at or beyond thread_count are invisible to the scan.
  always_comb begin
    pend = '0;
    for (int t = 0; t < T; t++) begin
      pend[t] = (t < int'(thread_count)) && (req_read_valid[t] || req_write_valid[t]);
    end
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    pick_rd  = 1'b0;
    idx      = '0;
    for (int i = 0; i < T; i++) begin
      idx = GW'((int'(rr_ptr) + i) % T);
      if (!pick_vld && pend[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
        pick_rd  = req_read_valid[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && pick_vld) begin
        grant_q <= pick_id;
        rd_q    <= pick_rd;
        addr_q  <= pick_rd ? req_read_address[pick_id] : req_write_address[pick_id];
        wdata_q <= req_write_data[pick_id];
      end
      if (state_q == S_MEM_READ && mem_read_ready) begin
        rdata_q[grant_q] <= mem_read_data;
      end
      if (state_q == S_RESPOND) begin
        rr_ptr <= (grant_q == GW'(T - 1)) ? '0 : grant_q + GW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pick_vld) state_d = pick_rd ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_read_ready) state_d = S_RESPOND;
      S_MEM_WRITE: if (mem_write_ready) state_d = S_RESPOND;
      S_RESPOND:   state_d = S_RELEASE;
      S_RELEASE:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read_valid  = (state_q == S_MEM_READ);
    mem_write_valid = (state_q == S_MEM_WRITE);
    busy            = (state_q != S_IDLE);
    req_read_ready  = '0;
    req_write_ready = '0;
    if (state_q == S_RESPOND) begin
      if (rd_q) req_read_ready[grant_q]  = 1'b1;
      else      req_write_ready[grant_q] = 1'b1;
    end
  end

  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign req_read_data     = rdata_q;
  assign grant_id          = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory with programmable wait states, requesters that drop
// valid on their ready pulse, and an event log of ready pulses checked against hand-computed vectors.
module tb_dmem_arbiter;

  logic             clk;
  logic             reset;
  logic [2:0]       thread_count;
  logic [3:0]       req_read_valid;
  logic [3:0][7:0]  req_read_address;
  logic [3:0]       req_read_ready;
  logic [3:0][7:0]  req_read_data;
  logic [3:0]       req_write_valid;
  logic [3:0][7:0]  req_write_address;
  logic [3:0][7:0]  req_write_data;
  logic [3:0]       req_write_ready;
  logic             mem_read_valid;
  logic [7:0]       mem_read_address;
  logic             mem_read_ready;
  logic [7:0]       mem_read_data;
  logic             mem_write_valid;
  logic [7:0]       mem_write_address;
  logic [7:0]       mem_write_data;
  logic             mem_write_ready;
  logic             busy;
  logic [1:0]       grant_id;

  dmem_arbiter #(
    .THREADS_PER_BLOCK (4),
    .DATA_MEM_ADDR_BITS(8),
    .DATA_MEM_DATA_BITS(8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .thread_count     (thread_count),
    .req_read_valid   (req_read_valid),
    .req_read_address (req_read_address),
    .req_read_ready   (req_read_ready),
    .req_read_data    (req_read_data),
    .req_write_valid  (req_write_valid),
    .req_write_address(req_write_address),
    .req_write_data   (req_write_data),
    .req_write_ready  (req_write_ready),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .mem_write_valid  (mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rd_wait = 0;
  int         wr_wait = 0;
  int         rcnt = 0;
  int         wcnt = 0;
  int         rd_vld_cycles = 0;
  int         wr_vld_cycles = 0;
  logic [7:0] last_rd_addr = '0;
  logic [7:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  logic [7:0] mem [256];
  int         ev_thr[$];
  int         ev_wr[$];
  int         ev_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    ev_thr.delete();
    ev_wr.delete();
    ev_cyc.delete();
    rd_vld_cycles = 0;
    wr_vld_cycles = 0;
  endtask

  // Memory model, requester valid-drop and ready-pulse logging, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      if (mem_read_valid) begin
        rd_vld_cycles++;
        last_rd_addr = mem_read_address;
        if (rcnt == rd_wait) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem[mem_read_address];
          rcnt = 0;
        end else rcnt++;
      end else rcnt = 0;
      if (mem_write_valid) begin
        wr_vld_cycles++;
        if (wcnt == wr_wait) begin
          mem_write_ready = 1'b1;
          mem[mem_write_address] = mem_write_data;
          last_wr_addr = mem_write_address;
          last_wr_data = mem_write_data;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
      for (int t = 0; t < 4; t++) begin
        if (req_read_ready[t]) begin
          ev_thr.push_back(t); ev_wr.push_back(0); ev_cyc.push_back(cyc);
          req_read_valid[t] = 1'b0;
        end
        if (req_write_ready[t]) begin
          ev_thr.push_back(t); ev_wr.push_back(1); ev_cyc.push_back(cyc);
          req_write_valid[t] = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 3 + 1);
    mem[8'h10] = 8'hAB;
    reset = 1'b0;
    thread_count = 3'd4;
    req_read_valid = '0;
    req_write_valid = '0;
    req_read_address = '0;
    req_write_address = '0;
    req_write_data = '0;
    mem_read_ready = 1'b0;
    mem_read_data = '0;
    mem_write_ready = 1'b0;
    run(3);

    // Reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_mem_vld", 32'({mem_read_valid, mem_write_valid}), 32'd0);
    check_eq("rst_req_rdy", 32'({req_read_ready, req_write_ready}), 32'd0);
    check_eq("rst_rdata", req_read_data, 32'd0);
    check_eq("rst_addr", 32'({mem_read_address, mem_write_address, mem_write_data}), 32'd0);
    reset = 1'b1;
    run(2);

    // Single read, thread 2, two wait states
    clear_log();
    rd_wait = 2;
    req_read_address[2] = 8'h10;
    req_read_valid[2] = 1'b1;
    run(12);
    check_eq("single_vld_cycles", 32'(rd_vld_cycles), 32'd3);
    check_eq("single_addr", 32'(last_rd_addr), 32'h10);
    check_eq("single_nevents", 32'(ev_thr.size()), 32'd1);
    if (ev_thr.size() >= 1) begin
      check_eq("single_thread", ev_thr[0], 32'd2);
      check_eq("single_is_read", ev_wr[0], 32'd0);
    end
    check_eq("single_rdata", 32'(req_read_data[2]), 32'hAB);
    check_eq("single_idle", 32'(busy), 32'd0);

    // Reset mid MEM_READ
    clear_log();
    rd_wait = 5;
    req_read_address[1] = 8'h11;
    req_read_valid[1] = 1'b1;
    run(2);
    check_eq("abort_in_read", 32'(mem_read_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_mem_vld", 32'(mem_read_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_addr", 32'(mem_read_address), 32'd0);
    check_eq("abort_rdata", req_read_data, 32'd0);
    req_read_valid[1] = 1'b0;
    run(3);
    reset = 1'b1;
    run(10);
    check_eq("abort_no_ready", 32'(ev_thr.size()), 32'd0);
    check_eq("abort_idle", 32'(busy), 32'd0);
    check_eq("abort_grant", 32'(grant_id), 32'd0);

    // Round robin, all four read at once, zero-wait memory
    clear_log();
    rd_wait = 0;
    for (int t = 0; t < 4; t++) req_read_address[t] = 8'(8'h20 + t);
    req_read_valid = 4'hF;
    run(25);
    check_eq("rr_nevents", 32'(ev_thr.size()), 32'd4);
    if (ev_thr.size() == 4) begin
      for (int k = 0; k < 4; k++) check_eq($sformatf("rr_order%0d", k), ev_thr[k], k);
      for (int k = 1; k < 4; k++) check_eq($sformatf("rr_gap%0d", k), ev_cyc[k] - ev_cyc[k-1], 32'd4);
    end
    check_eq("rr_rdata", req_read_data, 32'h6A676461);

    // Read and write from the same thread: read first, write on a later grant
    clear_log();
    req_read_address[1] = 8'h07;
    req_write_address[1] = 8'h05;
    req_write_data[1] = 8'h3C;
    req_read_valid[1] = 1'b1;
    req_write_valid[1] = 1'b1;
    run(15);
    check_eq("rw_nevents", 32'(ev_thr.size()), 32'd2);
    if (ev_thr.size() == 2) begin
      check_eq("rw_first_thr", ev_thr[0], 32'd1);
      check_eq("rw_first_is_wr", ev_wr[0], 32'd0);
      check_eq("rw_second_thr", ev_thr[1], 32'd1);
      check_eq("rw_second_is_wr", ev_wr[1], 32'd1);
    end
    check_eq("rw_rdata", 32'(req_read_data[1]), 32'h16);
    check_eq("rw_wr_addr", 32'(last_wr_addr), 32'h05);
    check_eq("rw_wr_data", 32'(last_wr_data), 32'h3C);
    check_eq("rw_mem", 32'(mem[5]), 32'h3C);
    check_eq("rw_wr_cycles", 32'(wr_vld_cycles), 32'd1);

    // Masking: thread_count=2 hides threads 2 and 3, thread_count=0 hides everything
    clear_log();
    thread_count = 3'd2;
    req_read_address[2] = 8'h40;
    req_read_address[3] = 8'h41;
    req_read_valid[3:2] = 2'b11;
    run(20);
    check_eq("mask_no_traffic", 32'(rd_vld_cycles), 32'd0);
    check_eq("mask_no_events", 32'(ev_thr.size()), 32'd0);
    check_eq("mask_idle", 32'(busy), 32'd0);
    thread_count = 3'd0;
    req_read_address[0] = 8'h02;
    req_read_valid[0] = 1'b1;
    run(15);
    check_eq("tc0_no_traffic", 32'(rd_vld_cycles), 32'd0);
    check_eq("tc0_idle", 32'(busy), 32'd0);
    thread_count = 3'd2;
    req_read_address[1] = 8'h03;
    req_read_valid[1] = 1'b1;
    run(20);
    check_eq("mask_nevents", 32'(ev_thr.size()), 32'd2);
    if (ev_thr.size() == 2) begin
      check_eq("mask_first", ev_thr[0], 32'd0);
      check_eq("mask_second", ev_thr[1], 32'd1);
    end
    check_eq("mask_rdata", 32'({req_read_data[1], req_read_data[0]}), 32'h0A07);
    check_eq("mask_still_pending", 32'(req_read_valid), 32'hC);
    req_read_valid = '0;
    thread_count = 3'd4;
    run(2);

    // Pointer wrap: serve thread 3, then threads 0 and 3 together -> 0 first
    clear_log();
    req_read_address[3] = 8'h30;
    req_read_valid[3] = 1'b1;
    run(10);
    req_read_address[0] = 8'h31;
    req_read_valid[0] = 1'b1;
    req_read_valid[3] = 1'b1;
    run(15);
    check_eq("wrap_nevents", 32'(ev_thr.size()), 32'd3);
    if (ev_thr.size() == 3) begin
      check_eq("wrap_prime", ev_thr[0], 32'd3);
      check_eq("wrap_first", ev_thr[1], 32'd0);
      check_eq("wrap_second", ev_thr[2], 32'd3);
    end
    check_eq("wrap_rdata0", 32'(req_read_data[0]), 32'h94);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
